// File: rtl/fpu_pkg.sv
// Shared FPU dispatch definitions: opcodes, dispatcher state encoding, counter sizing.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fpu_pkg;

    localparam logic [1:0] FPU_ADD  = 2'b00;
    localparam logic [1:0] FPU_SUB  = 2'b01;
    localparam logic [1:0] FPU_MUL  = 2'b10;
    localparam logic [1:0] FPU_SQRT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Wide enough to hold TIMEOUT-1 with one bit of headroom.
    function automatic int wait_cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// WAIT-cycle counter for the dispatcher; flags when the FPU has used its full budget.
// Latency: expired is combinational from the count register; count advances one per WAIT cycle.
// Backpressure: none; cleared on ISSUE, saturates at TIMEOUT-1 instead of wrapping.
module fpu_watchdog
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count WAIT cycles, holding at the last value rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/fixed_point_dispatcher.sv
// Single-outstanding dispatcher between a core and a fixed-point FPU (IDLE->ISSUE->WAIT->RESP).
// Latency: 3 cycles accept-to-resp_valid when the FPU is ready on the first WAIT cycle.
// Backpressure: req_ready only in IDLE; response held until resp_ready. FPU_TIMEOUT_EN adds WAIT abort.
module fixed_point_dispatcher
    import fpu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_operation,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_error,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    output logic             fpu_start,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready
);

    // The watchdog compares against TIMEOUT-1, so a budget below two cycles is meaningless.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("fixed_point_dispatcher: TIMEOUT must be at least 2");
    end

    state_t state;
    state_t state_next;
    logic   timeout_hit;

`ifdef FPU_TIMEOUT_EN
    fpu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ST_ISSUE),
        .count_en (state == ST_WAIT),
        .expired  (timeout_hit)
    );

    // Error flag: cleared on a real result, set on a watchdog abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_error <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (fpu_ready) begin
                resp_error <= 1'b0;
            end else if (timeout_hit) begin
                resp_error <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_error  = 1'b0;
`endif

    // State register; async reset drops ISSUE so fpu_start falls without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        fpu_start  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // fpu_ready wins over the watchdog on the final budget cycle.
                if (fpu_ready || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture: operands stay on the FPU bus until the next accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpu_operation <= FPU_ADD;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
        end else if ((state == ST_IDLE) && req_valid) begin
            fpu_operation <= req_operation;
            fpu_operand_1 <= req_operand_1;
            fpu_operand_2 <= req_operand_2;
        end
    end

    // Result capture in WAIT only; an abort returns zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_result <= '0;
        end else if (state == ST_WAIT) begin
            if (fpu_ready) begin
                resp_result <= fpu_result;
            end else if (timeout_hit) begin
                resp_result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_dispatcher.sv
module tb_fixed_point_dispatcher;

    localparam int W  = 32;
    localparam int TO = 8;
`ifdef FPU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_operation = 2'b00;
    logic [W-1:0] req_operand_1 = '0;
    logic [W-1:0] req_operand_2 = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_result;
    logic         resp_error;
    logic [W-1:0] fpu_operand_1;
    logic [W-1:0] fpu_operand_2;
    logic [1:0]   fpu_operation;
    logic         fpu_start;
    logic [W-1:0] fpu_result = '0;
    logic         fpu_ready = 1'b0;

    fixed_point_dispatcher #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operation (req_operation),
        .req_operand_1 (req_operand_1),
        .req_operand_2 (req_operand_2),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_error    (resp_error),
        .fpu_operand_1 (fpu_operand_1),
        .fpu_operand_2 (fpu_operand_2),
        .fpu_operation (fpu_operation),
        .fpu_start     (fpu_start),
        .fpu_result    (fpu_result),
        .fpu_ready     (fpu_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat_cyc;
        int           stall;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } iss_t;

    exp_t exp_q[$];
    iss_t iss_q[$];
    int   lat_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Q.10 fixed-point arithmetic, as the FPU would compute it.
    function automatic logic [W-1:0] isqrt(input logic [63:0] x);
        logic [63:0] r;
        logic [63:0] cand;
        r = 64'd0;
        for (int i = 31; i >= 0; i--) begin
            cand = r | (64'd1 << i);
            if (cand * cand <= x) r = cand;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] fpu_math(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2: begin
                p = 64'(a) * 64'(b);
                return W'(p >> 10);
            end
            default: return isqrt(64'(a) << 10);
        endcase
    endfunction

    // FPU model: result ready from WAIT cycle 'lat' onward (lat=0 means immediately).
    int fpu_k = 0;
    int fpu_lat = 0;
    bit fpu_busy = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (fpu_start) begin
            fpu_busy   = 1'b1;
            fpu_k      = 0;
            fpu_lat    = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            fpu_result = fpu_math(fpu_operation, fpu_operand_1, fpu_operand_2);
        end else if (fpu_busy) begin
            fpu_k++;
        end
        fpu_ready = fpu_busy && (fpu_k >= fpu_lat + 1);
    end

    // Response sink: holds resp_ready low for the configured number of RESP cycles.
    int stall_cnt = 0;
    always begin
        @(posedge clk);
        #2;
        if (resp_valid) begin
            resp_ready = (stall_cnt >= ((exp_q.size() != 0) ? exp_q[0].stall : 0));
            stall_cnt++;
        end else begin
            resp_ready = 1'b0;
            stall_cnt  = 0;
        end
    end

    // Monitor / scoreboard.
    int           cyc = 0;
    int           acc_cyc = 0;
    bit           prev_start = 1'b0;
    bit           prev_valid = 1'b0;
    bit           prev_rr = 1'b0;
    bit           prev_hs = 1'b0;
    logic [W-1:0] prev_res = '0;
    logic         prev_err = 1'b0;
    iss_t         last_iss;
    exp_t         e;
    always @(negedge clk) begin
        bit hs_now;
        cyc++;
        hs_now = 1'b0;
        if (reset) begin
            prev_start = 1'b0;
            prev_valid = 1'b0;
            prev_rr    = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (fpu_start) begin
                chk("issue_expected", 64'(iss_q.size() != 0), 64'd1);
                if (iss_q.size() != 0) begin
                    last_iss = iss_q.pop_front();
                    chk("fpu_operation", 64'(fpu_operation), 64'(last_iss.op));
                    chk("fpu_operand_1", 64'(fpu_operand_1), 64'(last_iss.a));
                    chk("fpu_operand_2", 64'(fpu_operand_2), 64'(last_iss.b));
                end
                chk("req_ready_in_issue", 64'(req_ready), 64'd0);
            end
            if (prev_start) chk("start_single_cycle", 64'(fpu_start), 64'd0);
            if (prev_valid && !prev_rr) begin
                chk("resp_held_valid", 64'(resp_valid), 64'd1);
                chk("resp_result_stable", 64'(resp_result), 64'(prev_res));
                chk("resp_error_stable", 64'(resp_error), 64'(prev_err));
            end
            if (resp_valid) begin
                chk("req_ready_in_resp", 64'(req_ready), 64'd0);
                chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    if (!prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat_cyc));
                    if (resp_ready) begin
                        e = exp_q.pop_front();
                        chk("resp_result", 64'(resp_result), 64'(e.res));
                        chk("resp_error", 64'(resp_error), 64'(e.err));
                        chk("operands_held", 64'(fpu_operand_1), 64'(last_iss.a));
                        hs_now = 1'b1;
                    end
                end
            end
            if (prev_hs && req_valid) chk("accept_after_handoff", 64'(req_ready), 64'd1);
            if (req_valid && req_ready) acc_cyc = cyc;
            prev_start = fpu_start;
            prev_valid = resp_valid;
            prev_rr    = resp_ready;
            prev_res   = resp_result;
            prev_err   = resp_error;
            prev_hs    = hs_now;
        end
    end

    // Driver: call at posedge+2. Returns at posedge+2 right after the accept edge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int stall, input bit hold);
        exp_t x;
        iss_t s;
        bit   ok;
        req_valid     = 1'b1;
        req_operation = op;
        req_operand_1 = a;
        req_operand_2 = b;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            if (TO_EN && (lat > TO - 1)) begin
                x.res     = '0;
                x.err     = 1'b1;
                x.lat_cyc = 2 + TO;
            end else begin
                x.res     = fpu_math(op, a, b);
                x.err     = 1'b0;
                x.lat_cyc = 3 + lat;
            end
            x.stall = stall;
            s.op = op;
            s.a  = a;
            s.b  = b;
            exp_q.push_back(x);
            iss_q.push_back(s);
            lat_q.push_back(lat);
        end
        @(posedge clk);
        #2;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    // Reset while a request is outstanding; extra=0 hits ISSUE, extra=2 hits WAIT.
    task automatic reset_midop(input int extra);
        send(2'd0, 32'h111, 32'h222, 1000, 0, 1'b0);
        if (extra > 0) begin
            repeat (extra) @(posedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("rst_fpu_start", 64'(fpu_start), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_fpu_op1", 64'(fpu_operand_1), 64'd0);
        chk("rst_fpu_op2", 64'(fpu_operand_2), 64'd0);
        @(negedge clk);
        exp_q.delete();
        iss_q.delete();
        lat_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        #3;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_result", 64'(resp_result), 64'd0);
        chk("reset_resp_error", 64'(resp_error), 64'd0);
        chk("reset_fpu_start", 64'(fpu_start), 64'd0);
        chk("reset_fpu_operation", 64'(fpu_operation), 64'd0);
        chk("reset_fpu_operand_1", 64'(fpu_operand_1), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;

        send(2'd0, 32'h600, 32'h800, 0, 0, 1'b0);
        drain();
        send(2'd2, 32'h600, 32'h800, 5, 0, 1'b0);
        drain();
        send(2'd3, 32'h1000, 32'h0, 20, 4, 1'b0);
        drain();
`ifdef FPU_TIMEOUT_EN
        send(2'd0, 32'h5, 32'h6, 1000, 1, 1'b0);
        drain();
`endif
        reset_midop(2);
        send(2'd1, 32'h900, 32'h300, 1, 0, 1'b0);
        drain();
        reset_midop(0);
        send(2'd0, 32'h1234, 32'h4321, 0, 2, 1'b0);
        drain();

        // Back-to-back with req_valid held high across the first transaction.
        send(2'd0, 32'h1, 32'h2, 2, 2, 1'b1);
        send(2'd1, 32'h5, 32'h3, 0, 0, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           lat;
            op  = 2'($urandom_range(0, 3));
            a   = W'($urandom_range(0, 32'h0003_FFFF));
            b   = W'($urandom_range(0, 32'h0000_FFFF));
            lat = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 6));
`ifndef FPU_TIMEOUT_EN
            if (lat > 6) lat = 9;
`endif
            send(op, a, b, lat, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2;
            end
        end
        req_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
